// File: rtl/pipelined_cla_adder.sv
// Pipelined two-level carry-lookahead adder/subtractor with valid/ready
// handshakes. Stage 0 holds bit/group propagate-generate terms, stage 1 the
// finished sum; any further stages are pure delay. With STAGES=1 the whole
// computation lands in a single register.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned BLOCK  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  input  logic             i_mode,
  input  logic             i_cin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result,
  output logic             o_overflow
);

  localparam int unsigned NG  = WIDTH / BLOCK;
  // Number of result-holding stages and the stage index of the first one
  localparam int unsigned RS  = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int unsigned OFF = STAGES - RS;

  // Front-end terms computed straight from the operands
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] fe_p;
  logic [WIDTH-1:0] fe_g;
  logic [NG-1:0]    fe_gg;
  logic [NG-1:0]    fe_gp;
  logic             fe_c0;

  // Back-end inputs: either registered front-end terms or the raw ones
  logic [WIDTH-1:0] be_p;
  logic [WIDTH-1:0] be_g;
  logic [NG-1:0]    be_gg;
  logic [NG-1:0]    be_gp;
  logic             be_c0;
  logic             be_mode;

  logic [NG:0]      be_gc;
  logic [WIDTH-1:0] be_bc;
  logic [WIDTH-1:0] be_sum;
  logic [WIDTH:0]   be_res;
  logic             be_ovf;

  // Handshake state
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] in_v;
  logic [STAGES-1:0] take;

  logic [WIDTH:0]    res_q [RS];
  logic [RS-1:0]     ovf_q;

  // Per-bit propagate/generate; subtraction inverts B and the carry-in
  always_comb begin
    b_eff = i_mode ? ~i_add2 : i_add2;
    fe_p  = i_add1 ^ b_eff;
    fe_g  = i_add1 & b_eff;
    fe_c0 = i_mode ? ~i_cin : i_cin;
  end

  // Group generate/propagate, flat within each BLOCK-bit group
  always_comb begin : p_group
    logic term;
    term  = 1'b0;
    fe_gg = '0;
    fe_gp = '0;
    for (int j = 0; j < int'(NG); j++) begin
      fe_gp[j] = &fe_p[j*BLOCK +: BLOCK];
      for (int k = 0; k < int'(BLOCK); k++) begin
        term = fe_g[j*BLOCK+k];
        for (int m = k + 1; m < int'(BLOCK); m++) term = term & fe_p[j*BLOCK+m];
        fe_gg[j] = fe_gg[j] | term;
      end
    end
  end

  if (STAGES >= 2) begin : g_split
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;
    logic [NG-1:0]    s1_gg;
    logic [NG-1:0]    s1_gp;
    logic             s1_c0;
    logic             s1_mode;

    // First stage captures lookahead terms together with mode and carry-in
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        s1_p    <= '0;
        s1_g    <= '0;
        s1_gg   <= '0;
        s1_gp   <= '0;
        s1_c0   <= 1'b0;
        s1_mode <= 1'b0;
      end else if (take[0] && i_valid) begin
        s1_p    <= fe_p;
        s1_g    <= fe_g;
        s1_gg   <= fe_gg;
        s1_gp   <= fe_gp;
        s1_c0   <= fe_c0;
        s1_mode <= i_mode;
      end
    end

    assign be_p    = s1_p;
    assign be_g    = s1_g;
    assign be_gg   = s1_gg;
    assign be_gp   = s1_gp;
    assign be_c0   = s1_c0;
    assign be_mode = s1_mode;
  end else begin : g_flat
    assign be_p    = fe_p;
    assign be_g    = fe_g;
    assign be_gg   = fe_gg;
    assign be_gp   = fe_gp;
    assign be_c0   = fe_c0;
    assign be_mode = i_mode;
  end

  // Second-level lookahead across groups, then flat in-group bit carries
  always_comb begin : p_carry
    logic term;
    logic acc;
    term  = 1'b0;
    acc   = 1'b0;
    be_gc = '0;
    be_gc[0] = be_c0;
    for (int j = 1; j <= int'(NG); j++) begin
      acc = 1'b0;
      for (int k = 0; k < j; k++) begin
        term = be_gg[k];
        for (int m = k + 1; m < j; m++) term = term & be_gp[m];
        acc = acc | term;
      end
      term = be_c0;
      for (int m = 0; m < j; m++) term = term & be_gp[m];
      be_gc[j] = acc | term;
    end
    be_bc = '0;
    for (int j = 0; j < int'(NG); j++) begin
      for (int i = 0; i < int'(BLOCK); i++) begin
        term = be_gc[j];
        for (int m = 0; m < i; m++) term = term & be_p[j*BLOCK+m];
        acc = term;
        for (int k = 0; k < i; k++) begin
          term = be_g[j*BLOCK+k];
          for (int m = k + 1; m < i; m++) term = term & be_p[j*BLOCK+m];
          acc = acc | term;
        end
        be_bc[j*BLOCK+i] = acc;
      end
    end
    be_sum = be_p ^ be_bc;
    // Borrow is the inverted carry-out in subtract mode
    be_res = {be_mode ^ be_gc[NG], be_sum};
    // Operand signs agree exactly when the MSB propagate is 0; g then equals that sign
    be_ovf = ~be_p[WIDTH-1] & (be_sum[WIDTH-1] ^ be_g[WIDTH-1]);
  end

  // A stage may capture if it, or any stage after it, frees up this cycle
  always_comb begin : p_take
    logic acc;
    acc  = 1'b0;
    take = '0;
    in_v = '0;
    for (int i = 0; i < int'(STAGES); i++) begin
      acc = i_ready;
      for (int k = i; k < int'(STAGES); k++) acc = acc | ~v_q[k];
      take[i] = acc;
      in_v[i] = (i == 0) ? i_valid : v_q[i-1];
    end
  end

  // Stage valid bits advance with their entries
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v_q <= '0;
    end else begin
      for (int i = 0; i < int'(STAGES); i++) begin
        if (take[i]) v_q[i] <= in_v[i];
      end
    end
  end

  // Result stages load only real entries so an empty pipe keeps the last value
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < int'(RS); r++) res_q[r] <= '0;
      ovf_q <= '0;
    end else begin
      if (take[OFF] && in_v[OFF]) begin
        res_q[0] <= be_res;
        ovf_q[0] <= be_ovf;
      end
      for (int r = 1; r < int'(RS); r++) begin
        if (take[OFF+r] && in_v[OFF+r]) begin
          res_q[r] <= res_q[r-1];
          ovf_q[r] <= ovf_q[r-1];
        end
      end
    end
  end

  assign o_ready    = take[0];
  assign o_valid    = v_q[STAGES-1];
  assign o_result   = res_q[RS-1];
  assign o_overflow = ovf_q[RS-1];

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder (WIDTH=8, BLOCK=4, STAGES=2).
module tb_pipelined_cla_adder;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] i_add1;
  logic [7:0] i_add2;
  logic       i_mode;
  logic       i_cin;
  logic       o_valid;
  logic       i_ready;
  logic [8:0] o_result;
  logic       o_overflow;

  pipelined_cla_adder #(.WIDTH(8), .BLOCK(4), .STAGES(2)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_add1     (i_add1),
    .i_add2     (i_add2),
    .i_mode     (i_mode),
    .i_cin      (i_cin),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_result   (o_result),
    .o_overflow (o_overflow)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int out_cnt = 0;
  int stalls = 0;
  logic rand_ready = 1'b0;
  logic [9:0] exp_q [$];   // {overflow, result}

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Reference: plain integer arithmetic
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic m, input logic c);
    int ua, ub, sa, sbv, r, sv;
    logic [8:0] res;
    ua  = int'(a);
    ub  = int'(b);
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    if (!m) begin
      r   = ua + ub + int'(c);
      res = 9'(r);
      sv  = sa + sbv + int'(c);
    end else begin
      r   = ua - ub - int'(c);
      res = {(ua < ub + int'(c)), 8'(r)};
      sv  = sa - sbv - int'(c);
    end
    return {(sv > 127 || sv < -128), res};
  endfunction

  // Offer one operation; push its expectation the moment it will be accepted
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic m,
                      input logic c, input logic [9:0] exp_v);
    logic acc;
    int t;
    acc = 1'b0;
    t = 0;
    i_add1 = a; i_add2 = b; i_mode = m; i_cin = c; i_valid = 1'b1;
    while (!acc && t < 200) begin
      @(negedge i_clk);
      acc = o_ready;
      if (acc) exp_q.push_back(exp_v);
      @(posedge i_clk);
      #1;
      if (!acc) stalls++;
      t++;
    end
    i_valid = 1'b0;
    if (!acc) begin
      total_cnt++;
      $display("FAIL send_timeout: got o_ready=0 for 200 cycles expected acceptance");
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge i_clk);
      t++;
    end
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every output transfer must match the oldest expectation
  always @(negedge i_clk) begin
    if (i_rst_n && o_valid && i_ready) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_output: got result %0h expected no output", o_result);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("result", 32'(o_result), 32'(e[8:0]));
        check("overflow", 32'(o_overflow), 32'(e[9]));
      end
    end
  end

  // Random consumer readiness when enabled
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if (rand_ready) i_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [7:0] vals [12] = '{8'h00, 8'h01, 8'h02, 8'h0F, 8'h55, 8'h7F,
                            8'h80, 8'h81, 8'hAA, 8'hF0, 8'hFE, 8'hFF};
  logic [7:0] bp_a [4] = '{8'h01, 8'h03, 8'h10, 8'hF0};
  logic [7:0] bp_b [4] = '{8'h02, 8'h04, 8'h01, 8'h20};
  logic       bp_m [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic       bp_c [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [9:0] bp_e [4] = '{10'h003, 10'h007, 10'h00F, 10'h111};

  initial begin
    int k, out0, stall0;
    logic acc;
    i_rst_n = 1'b0; i_valid = 1'b1; i_ready = 1'b1;
    i_add1 = 8'd3; i_add2 = 8'd4; i_mode = 1'b0; i_cin = 1'b0;

    // Reset held with valid operands offered
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_o_result", 32'(o_result), 32'd0);
    check("rst_o_overflow", 32'(o_overflow), 32'd0);
    check("rst_o_ready", 32'(o_ready), 32'd1);
    i_valid = 1'b0;
    i_rst_n = 1'b1;
    repeat (4) @(posedge i_clk);
    #1;
    check("post_rst_no_output", 32'(out_cnt), 32'd0);

    // Latency: accepted at edge N, output transfer at edge N+2
    send(8'd200, 8'd100, 1'b0, 1'b0, {1'b0, 9'h12C});
    check("lat_after_n", 32'(o_valid), 32'd0);
    @(posedge i_clk);
    #1;
    check("lat_after_n1_valid", 32'(o_valid), 32'd1);
    check("lat_after_n1_result", 32'(o_result), 32'h12C);

    // Directed add/subtract vectors
    send(8'd127, 8'd1,   1'b0, 1'b0, {1'b1, 9'h080});
    send(8'hFF,  8'h00,  1'b0, 1'b1, {1'b0, 9'h100});
    send(8'd5,   8'd7,   1'b1, 1'b0, {1'b0, 9'h1FE});
    send(8'h80,  8'd1,   1'b1, 1'b0, {1'b1, 9'h07F});
    send(8'd10,  8'd3,   1'b1, 1'b1, {1'b0, 9'h006});
    send(8'h00,  8'h00,  1'b1, 1'b0, {1'b0, 9'h000});
    send(8'h00,  8'h00,  1'b1, 1'b1, {1'b0, 9'h1FF});
    send(8'h7F,  8'hFF,  1'b1, 1'b0, {1'b1, 9'h180});
    drain();

    // Back-to-back corner-value sweep, consumer always ready
    out0 = out_cnt;
    stall0 = stalls;
    for (int ia = 0; ia < 12; ia++)
      for (int ib = 0; ib < 12; ib++)
        for (int mc = 0; mc < 4; mc++)
          send(vals[ia], vals[ib], 1'(mc >> 1), 1'(mc),
               model(vals[ia], vals[ib], 1'(mc >> 1), 1'(mc)));
    check("stream_no_stall", 32'(stalls - stall0), 32'd0);
    drain();
    check("stream_count", 32'(out_cnt - out0), 32'd576);

    // Backpressure: consumer stalled for 5 cycles while 4 operations are offered
    out0 = out_cnt;
    i_ready = 1'b0;
    k = 0;
    i_add1 = bp_a[0]; i_add2 = bp_b[0]; i_mode = bp_m[0]; i_cin = bp_c[0];
    i_valid = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge i_clk);
      acc = o_ready;
      if (o_valid) check("stall_hold", 32'(o_result), 32'h003);
      if (acc) exp_q.push_back(bp_e[k]);
      @(posedge i_clk);
      #1;
      if (acc) begin
        k++;
        i_add1 = bp_a[k]; i_add2 = bp_b[k]; i_mode = bp_m[k]; i_cin = bp_c[k];
      end
    end
    check("bp_accepted", 32'(k), 32'd2);
    check("bp_o_ready_low", 32'(o_ready), 32'd0);
    i_valid = 1'b0;
    i_ready = 1'b1;
    send(bp_a[2], bp_b[2], bp_m[2], bp_c[2], bp_e[2]);
    send(bp_a[3], bp_b[3], bp_m[3], bp_c[3], bp_e[3]);
    drain();
    check("bp_count", 32'(out_cnt - out0), 32'd4);

    // Random consumer readiness
    out0 = out_cnt;
    rand_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      logic [7:0] a, b;
      logic m, c;
      a = 8'($urandom);
      b = 8'($urandom);
      m = 1'($urandom);
      c = 1'($urandom);
      send(a, b, m, c, model(a, b, m, c));
    end
    rand_ready = 1'b0;
    @(posedge i_clk);
    #2;
    i_ready = 1'b1;
    drain();
    check("rand_count", 32'(out_cnt - out0), 32'd200);

    // Reset pulse with two operations in flight
    i_ready = 1'b0;
    send(8'd11, 8'd22, 1'b0, 1'b0, {1'b0, 9'h021});
    send(8'd33, 8'd44, 1'b0, 1'b0, {1'b0, 9'h04D});
    check("inflight_valid", 32'(o_valid), 32'd1);
    #1;
    i_rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(o_valid), 32'd0);
    check("async_rst_result", 32'(o_result), 32'd0);
    check("async_rst_ready", 32'(o_ready), 32'd1);
    exp_q.delete();
    #1;
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    out0 = out_cnt;
    repeat (6) @(posedge i_clk);
    #1;
    check("flushed_no_output", 32'(out_cnt - out0), 32'd0);

    // Pipeline usable again after reset
    send(8'h7F, 8'hFF, 1'b1, 1'b0, {1'b1, 9'h180});
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
